// File: rtl/button_event_arbiter_if.sv
// button_event_arbiter_if: button inputs, event handshake and status outputs of the arbiter.
interface button_event_arbiter_if #(
    parameter int N     = 4,
    parameter int IDX_W = 2
);
    logic [N-1:0]     BTN;
    logic             EV_READY;
    logic             EV_VALID;
    logic [IDX_W-1:0] EV_ID;
    logic [N-1:0]     PENDING;
    logic             DROP;
    modport master (input BTN, EV_READY, output EV_VALID, EV_ID, PENDING, DROP);
    modport slave  (output BTN, EV_READY, input EV_VALID, EV_ID, PENDING, DROP);
endinterface

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: synchronises N buttons and serialises their presses round-robin over valid/ready.
// Define BTN_REPEAT_EN to add per-button auto-repeat after REPEAT_CYCLES of hold.
module button_event_arbiter #(
    parameter int N             = 4,
    parameter int IDX_W         = 2,
    parameter int REPEAT_CYCLES = 25000000
) (
    input logic CLK,
    input logic RST,
    button_event_arbiter_if.master bus
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t state, state_nxt;
    logic [N-1:0] s1, s2, s3, rise, clr, pend_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt, win, id_nxt;
    logic valid_nxt, drop_nxt, hs;
`ifdef BTN_REPEAT_EN
    localparam int CW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(REPEAT_CYCLES - 1);
    logic [CW-1:0] cnt [N];
    logic [N-1:0] edge_r, fire;
    assign edge_r = s2 & ~s3;
    always_comb begin
        for (int i = 0; i < N; i++) fire[i] = s2[i] & ~edge_r[i] & (cnt[i] == CMAX);
    end
    assign rise = edge_r | fire;
    always_ff @(posedge CLK) begin
        for (int i = 0; i < N; i++)
            cnt[i] <= (RST | edge_r[i] | ~s2[i] | fire[i]) ? '0 : cnt[i] + 1'b1;
    end
`else
    logic unused_rc;
    assign unused_rc = REPEAT_CYCLES > 0;
    assign rise = s2 & ~s3;
`endif
    always_comb begin
        hs = (state == OFFER) && bus.EV_READY;
        clr = '0;
        if (hs) clr[bus.EV_ID] = 1'b1;
        // a rise coinciding with the clear re-arms the bit and is not a collision
        pend_nxt = (bus.PENDING & ~clr) | rise;
        drop_nxt = |(rise & bus.PENDING & ~clr);
    end
    // scanning downwards lets the nearest set bit at or after ptr win last
    always_comb begin
        win = '0;
        for (int k = N - 1; k >= 0; k--)
            if (bus.PENDING[(int'(ptr) + k) % N]) win = IDX_W'((int'(ptr) + k) % N);
    end
    always_comb begin
        state_nxt = state;
        valid_nxt = bus.EV_VALID;
        id_nxt = bus.EV_ID;
        ptr_nxt = ptr;
        if (state == IDLE && |bus.PENDING) begin
            state_nxt = OFFER;
            valid_nxt = 1'b1;
            id_nxt = win;
        end else if (hs) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            ptr_nxt = (int'(bus.EV_ID) == N - 1) ? '0 : bus.EV_ID + 1'b1;
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            ptr <= '0;
            bus.PENDING <= '0;
            bus.EV_VALID <= 1'b0;
            bus.EV_ID <= '0;
            bus.DROP <= 1'b0;
        end else begin
            s1 <= bus.BTN;
            s2 <= s1;
            s3 <= s2;
            ptr <= ptr_nxt;
            bus.PENDING <= pend_nxt;
            bus.EV_VALID <= valid_nxt;
            bus.EV_ID <= id_nxt;
            bus.DROP <= drop_nxt;
        end
    end
endmodule
